// File: rtl/servo_pwm_array.sv
// rtl/servo_pwm_array.sv - multi-channel servo PWM with per-channel ramping, clamping and frame-aligned duty update
module servo_pwm_array #(
    parameter int CH       = 4,
    parameter int DUTY_W   = 20,
    parameter int GAP_W    = 12,
    parameter int PERIOD   = 1_000_000,
    parameter int DUTY_MIN = 25_000,
    parameter int DUTY_MAX = 125_000,
    parameter int DUTY_RST = 75_000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               wr_en,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch,
    input  logic [DUTY_W-1:0]                  wr_duty,
    input  logic [GAP_W-1:0]                   wr_gap,
    output logic [CH-1:0]                      pwm_out,
    output logic [CH-1:0]                      settled,
    output logic                               frame_start
);

    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [DUTY_W-1:0] D_MIN = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] D_MAX = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] D_RST = DUTY_W'(DUTY_RST);
    localparam logic [DUTY_W-1:0] LAST  = DUTY_W'(PERIOD - 1);

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] target [CH];
    logic [DUTY_W-1:0] cur    [CH];
    logic [DUTY_W-1:0] shadow [CH];
    logic [GAP_W-1:0]  gap    [CH];
    logic [GAP_W-1:0]  gcnt   [CH];

    logic [DUTY_W-1:0] wr_clamped;
    logic [CH-1:0]     wr_hit;
    logic              frame_end;

    assign frame_end = (cnt == LAST);

    // Out-of-range channel indices simply match no channel.
    always_comb begin
        wr_clamped = wr_duty;
        if (wr_duty < D_MIN) begin
            wr_clamped = D_MIN;
        end else if (wr_duty > D_MAX) begin
            wr_clamped = D_MAX;
        end
        wr_hit  = '0;
        settled = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i]  = wr_en && (wr_ch == CH_W'(i));
            settled[i] = (cur[i] == target[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= LAST;
            pwm_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            if (en) begin
                cnt <= frame_end ? '0 : cnt + DUTY_W'(1);
            end else begin
                cnt <= LAST;
            end
            frame_start <= en && (cnt == '0);
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= en && (cnt < shadow[i]);
            end
        end
    end

    // A write takes priority over a ramp step and restarts the step timer from the present cur.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (!rst_n) begin
                target[i] <= D_RST;
                cur[i]    <= D_RST;
                shadow[i] <= D_RST;
                gap[i]    <= '0;
                gcnt[i]   <= '0;
            end else begin
                if (frame_end) begin
                    shadow[i] <= cur[i];
                end
                if (wr_hit[i]) begin
                    target[i] <= wr_clamped;
                    gap[i]    <= wr_gap;
                    gcnt[i]   <= '0;
                end else if (cur[i] == target[i]) begin
                    gcnt[i] <= '0;
                end else if (gap[i] == '0) begin
                    cur[i] <= target[i];
                end else if (gcnt[i] == gap[i] - GAP_W'(1)) begin
                    cur[i]  <= (cur[i] < target[i]) ? cur[i] + DUTY_W'(1) : cur[i] - DUTY_W'(1);
                    gcnt[i] <= '0;
                end else begin
                    gcnt[i] <= gcnt[i] + GAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_array.sv
// tb/tb_servo_pwm_array.sv - self-checking bench for servo_pwm_array
module tb_servo_pwm_array;

    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, wr_en;
    logic [1:0]  wr_ch;
    logic [19:0] wr_duty;
    logic [11:0] wr_gap;
    logic [3:0]  pwm_out, settled;
    logic        frame_start;

    logic        en5, wr_en5;
    logic [2:0]  wr_ch5;
    logic [19:0] wr_duty5;
    logic [11:0] wr_gap5;
    logic [4:0]  pwm5, settled5;
    logic        fs5;

    servo_pwm_array #(.CH(4), .DUTY_W(20), .GAP_W(12), .PERIOD(100),
                      .DUTY_MIN(10), .DUTY_MAX(90), .DUTY_RST(50)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .wr_gap(wr_gap), .pwm_out(pwm_out),
        .settled(settled), .frame_start(frame_start)
    );

    servo_pwm_array #(.CH(5), .DUTY_W(20), .GAP_W(12), .PERIOD(100),
                      .DUTY_MIN(10), .DUTY_MAX(90), .DUTY_RST(50)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en5), .wr_en(wr_en5), .wr_ch(wr_ch5),
        .wr_duty(wr_duty5), .wr_gap(wr_gap5), .pwm_out(pwm5),
        .settled(settled5), .frame_start(fs5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-frame high-width and period recorder, finalised at each frame_start.
    int acc [CH] = '{default: 0};
    int fw  [CH] = '{default: 0};
    int plen = 0;
    int fp = 0;
    int nframes = 0;

    always @(negedge clk) begin
        if (frame_start) begin
            for (int c = 0; c < CH; c++) begin
                fw[c]  = acc[c];
                acc[c] = int'(pwm_out[c]);
            end
            fp   = plen;
            plen = 1;
            nframes++;
        end else begin
            for (int c = 0; c < CH; c++) acc[c] += int'(pwm_out[c]);
            plen++;
        end
    end

    task automatic wait_frames(input int n);
        int start;
        int t;
        #1;
        start = nframes;
        t = 0;
        while (nframes < start + n && t < 300 * n) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (nframes < start + n) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_wait_timeout: got %0d frames, expected %0d", nframes - start, n);
        end
    endtask

    task automatic wr(input int ch, input int duty, input int gap);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = 20'(duty);
        wr_gap  = 12'(gap);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    typedef struct {
        int ch;
        int duty;
        int gap;
        int w;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int bad;
        vecs[0] = '{2, 5,      0, 10};
        vecs[1] = '{2, 200,    0, 90};
        vecs[2] = '{1, 10,     0, 10};
        vecs[3] = '{3, 90,     0, 90};
        vecs[4] = '{0, 33,     0, 33};
        vecs[5] = '{1, 0,      0, 10};
        vecs[6] = '{3, 89,     0, 89};
        vecs[7] = '{0, 100000, 0, 90};

        rst_n = 1'b0; en = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_gap = '0;
        en5 = 1'b0; wr_en5 = 1'b0; wr_ch5 = '0; wr_duty5 = '0; wr_gap5 = '0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_settled", settled, 4'hF);
        chk("rst_settled5", settled5, 5'h1F);
        rst_n = 1'b1;

        // Neutral output after reset
        wait_frames(2);
        for (int c = 0; c < CH; c++) chk($sformatf("neutral_w%0d", c), fw[c], 50);
        chk("neutral_period", fp, 100);
        chk("neutral_settled", settled, 4'hF);

        // Ramp ch1 50->60, gap 3, written 80 cycles into a frame
        wait_frames(1);
        repeat (79) @(negedge clk);
        wr(1, 60, 3);
        n = 0;
        while (!settled[1] && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ramp_up_cycles", n, 30);
        wait_frames(1);
        chk("ramp_mid_w1", fw[1], 56);
        chk("ramp_mid_w0", fw[0], 50);
        wait_frames(1);
        chk("ramp_end_w1", fw[1], 60);

        // Ch0 up toward 80 at gap 2, redirected to 40 when cur reaches 60
        wr(0, 80, 2);
        n = 0;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (k == 20) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 20'd40; wr_gap = 12'd2;
            end
            if (k == 21) wr_en = 1'b0;
            if (settled[0]) break;
            n++;
            if (!settled[3]) bad++;
            @(negedge clk);
        end
        chk("redirect_cycles", n, 61);
        chk("redirect_ch3_quiet", bad, 0);
        wait_frames(2);
        chk("redirect_w0", fw[0], 40);
        chk("redirect_w3", fw[3], 50);

        // Clamp and immediate-update table
        foreach (vecs[i]) begin
            wr(vecs[i].ch, vecs[i].duty, vecs[i].gap);
            wait_frames(2);
            chk($sformatf("vec%0d_width", i), fw[vecs[i].ch], vecs[i].w);
            chk($sformatf("vec%0d_settled", i), settled, 4'hF);
        end

        // Disable mid-pulse, write while disabled, re-enable
        wait_frames(1);
        repeat (10) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 5) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 20'd70; wr_gap = 12'd0;
            end
            if (k == 6) wr_en = 1'b0;
            if (pwm_out != 4'h0 || frame_start) bad++;
            @(negedge clk);
        end
        chk("disabled_quiet", bad, 0);
        chk("disabled_settled", settled, 4'hF);
        en = 1'b1;
        @(negedge clk);
        chk("reenable_fs0", frame_start, 0);
        chk("reenable_pwm0", pwm_out, 0);
        @(negedge clk);
        chk("reenable_fs1", frame_start, 1);
        chk("reenable_pwm_ch0", pwm_out[0], 1);
        wait_frames(1);
        chk("reenable_w0", fw[0], 70);
        chk("reenable_w3", fw[3], 89);

        // Reset pulse mid-ramp
        wr(1, 90, 5);
        repeat (20) @(negedge clk);
        chk("midramp_unsettled", settled[1], 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_settled", settled, 4'hF);
        chk("midrst_pwm", pwm_out, 0);
        chk("midrst_fs", frame_start, 0);
        rst_n = 1'b1;
        wait_frames(2);
        for (int c = 0; c < CH; c++) chk($sformatf("postrst_w%0d", c), fw[c], 50);
        chk("postrst_period", fp, 100);

        // Out-of-range channel on a five-channel instance, then an in-range control write
        wr_en5 = 1'b1; wr_ch5 = 3'd5; wr_duty5 = 20'd10; wr_gap5 = 12'd0;
        @(negedge clk);
        wr_ch5 = 3'd7;
        @(negedge clk);
        wr_en5 = 1'b0;
        repeat (3) @(negedge clk);
        chk("oor_settled5", settled5, 5'h1F);
        chk("oor_pwm5", pwm5, 0);
        wr_en5 = 1'b1; wr_ch5 = 3'd4;
        @(negedge clk);
        wr_en5 = 1'b0;
        chk("inrange_settled5", settled5, 5'h0F);
        @(negedge clk);
        chk("inrange_settled5_done", settled5, 5'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
